// File: rtl/tt_scanner.sv
// Sequential truth-table scanner for a 4-input combinational function.
// It steps vec through 0..15, captures the response and compares it with a golden table.
module tt_scanner #(
  parameter int unsigned SETTLE   = 1,
  parameter logic [15:0] EXPECTED = 16'hF232
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        dut_f,
  output logic [3:0]  vec,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt,
  output logic [4:0]  ones,
  output logic        mismatch,
  output logic [3:0]  first_fail
);

  localparam int unsigned CNT_W   = 3;
  localparam int unsigned VEC_W   = 4;
  localparam int unsigned ONES_W  = 5;
  localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(SETTLE);
  localparam logic [VEC_W-1:0] VEC_LAST   = VEC_W'(15);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   settle_cnt;
  logic               fail_seen;

  // Scan controller: all outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      fail_seen  <= 1'b0;
      vec        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      tt         <= '0;
      ones       <= '0;
      mismatch   <= 1'b0;
      first_fail <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_SCAN;
            settle_cnt <= '0;
            fail_seen  <= 1'b0;
            vec        <= '0;
            busy       <= 1'b1;
            tt         <= '0;
            ones       <= '0;
            mismatch   <= 1'b0;
            first_fail <= '0;
          end
        end

        S_SCAN: begin
          if (settle_cnt < SETTLE_MAX) begin
            settle_cnt <= settle_cnt + CNT_W'(1);
          end else begin
            tt[vec] <= dut_f;
            if (dut_f) begin
              ones <= ones + ONES_W'(1);
            end
            // Only the lowest failing vector is recorded.
            if ((dut_f != EXPECTED[vec]) && !fail_seen) begin
              first_fail <= vec;
              mismatch   <= 1'b1;
              fail_seen  <= 1'b1;
            end
            if (vec != VEC_LAST) begin
              vec        <= vec + VEC_W'(1);
              settle_cnt <= '0;
            end else begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_scanner.sv
// Scoreboard bench for tt_scanner: two instances (SETTLE=1 and SETTLE=0) driven by
// behavioural functions under test; expected scan results are queued at each start.
module tb_tt_scanner;

  localparam logic [15:0] GOLDEN = 16'hF232;

  typedef struct packed {
    logic [15:0] tt;
    logic [4:0]  ones;
    logic        mm;
    logic [3:0]  ff;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, start1, f1, busy1, done1, mm1;
  logic [3:0]  vec1, ff1;
  logic [15:0] tt1;
  logic [4:0]  ones1;

  logic        rst0, start0, f0, busy0, done0, mm0;
  logic [3:0]  vec0, ff0;
  logic [15:0] tt0;
  logic [4:0]  ones0;

  int mode1, mode0;
  int sel;
  int checks, failures;
  exp_t sb[$];

  logic        s_busy, s_done, s_mm;
  logic [3:0]  s_vec, s_ff;
  logic [15:0] s_tt;
  logic [4:0]  s_ones;

  function automatic logic golden_f(logic [3:0] v);
    return (~v[1] & v[0]) | (v[2] & ~v[1]) | (v[3] & v[2]);
  endfunction

  // 0: golden, 1: tied 0, 2: tied 1, 3: golden with vec=9 inverted
  function automatic logic model_f(int mode, logic [3:0] v);
    case (mode)
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return golden_f(v) ^ (v == 4'd9);
      default: return golden_f(v);
    endcase
  endfunction

  function automatic exp_t model_scan(int mode);
    exp_t e;
    logic [15:0] gold;
    logic [3:0] v;
    logic r;
    gold = GOLDEN;
    e = '0;
    for (int k = 0; k < 16; k++) begin
      v = 4'(k);
      r = model_f(mode, v);
      e.tt[k] = r;
      if (r) e.ones = e.ones + 5'd1;
      if ((r != gold[k]) && !e.mm) begin
        e.mm = 1'b1;
        e.ff = v;
      end
    end
    return e;
  endfunction

  always_comb f1 = model_f(mode1, vec1);
  always_comb f0 = model_f(mode0, vec0);

  always_comb begin
    s_busy = (sel != 0) ? busy1 : busy0;
    s_done = (sel != 0) ? done1 : done0;
    s_mm   = (sel != 0) ? mm1   : mm0;
    s_vec  = (sel != 0) ? vec1  : vec0;
    s_ff   = (sel != 0) ? ff1   : ff0;
    s_tt   = (sel != 0) ? tt1   : tt0;
    s_ones = (sel != 0) ? ones1 : ones0;
  end

  tt_scanner #(.SETTLE(1), .EXPECTED(16'hF232)) u_dut1 (
    .clk(clk), .rst(rst1), .start(start1), .dut_f(f1), .vec(vec1), .busy(busy1),
    .done(done1), .tt(tt1), .ones(ones1), .mismatch(mm1), .first_fail(ff1)
  );

  tt_scanner #(.SETTLE(0), .EXPECTED(16'hF232)) u_dut0 (
    .clk(clk), .rst(rst0), .start(start0), .dut_f(f0), .vec(vec0), .busy(busy0),
    .done(done0), .tt(tt0), .ones(ones0), .mismatch(mm0), .first_fail(ff0)
  );

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(logic val);
    if (sel != 0) start1 = val;
    else start0 = val;
  endtask

  // Queue the expectation, pulse (or hold) start; returns at the negedge after E0.
  task automatic kick(int mode, bit hold);
    if (sel != 0) mode1 = mode;
    else mode0 = mode;
    sb.push_back(model_scan(mode));
    set_start(1'b1);
    @(negedge clk);
    if (!hold) set_start(1'b0);
    check("kick_busy", 32'(s_busy), 32'd1);
    check("kick_vec", 32'(s_vec), 32'd0);
  endtask

  // Follow the scan from the negedge after E0 to done, then compare with the scoreboard.
  task automatic finish(int settle);
    int n = 0;
    int bad_busy = 0;
    int bad_vec = 0;
    int lat = 16 * (settle + 1);
    exp_t e;
    while (s_done !== 1'b1 && n < 200) begin
      if (s_busy !== 1'b1) bad_busy++;
      if (s_vec !== 4'(n / (settle + 1))) bad_vec++;
      @(negedge clk);
      n++;
    end
    check("done_latency", 32'(n), 32'(lat));
    check("scan_busy", 32'(bad_busy), 32'd0);
    check("scan_vec_seq", 32'(bad_vec), 32'd0);
    check("done_busy_low", 32'(s_busy), 32'd0);
    check("end_vec", 32'(s_vec), 32'd15);
    if (sb.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
      e = '0;
    end else begin
      e = sb.pop_front();
      check("sb_tt", 32'(s_tt), 32'(e.tt));
      check("sb_ones", 32'(s_ones), 32'(e.ones));
      check("sb_mismatch", 32'(s_mm), 32'(e.mm));
      check("sb_first_fail", 32'(s_ff), 32'(e.ff));
    end
    @(negedge clk);
    check("done_one_cycle", 32'(s_done), 32'd0);
    check("idle_busy", 32'(s_busy), 32'd0);
    check("hold_tt", 32'(s_tt), 32'(e.tt));
  endtask

  initial begin
    checks = 0; failures = 0;
    sel = 1; mode1 = 0; mode0 = 0;
    rst1 = 1'b1; rst0 = 1'b1; start1 = 1'b0; start0 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", 32'({vec1, busy1, done1, tt1, ones1, mm1, ff1}), 32'd0);
    rst1 = 1'b0; rst0 = 1'b0;
    @(negedge clk);

    // Golden function, SETTLE=1
    sel = 1;
    kick(0, 1'b0);
    finish(1);
    check("golden_tt", 32'(s_tt), 32'h0000_F232);
    check("golden_ones", 32'(s_ones), 32'd8);

    // Tied low
    kick(1, 1'b0);
    finish(1);
    check("tie0_first_fail", 32'(s_ff), 32'd1);

    // Tied high
    kick(2, 1'b0);
    finish(1);
    check("tie1_tt", 32'(s_tt), 32'h0000_FFFF);
    check("tie1_ones", 32'(s_ones), 32'd16);

    // Reset mid-scan at vec=7, with start asserted on the reset edge
    mode1 = 0;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int i = 0; i < 100 && vec1 !== 4'd7; i++) @(negedge clk);
    check("reach_vec7", 32'(vec1), 32'd7);
    rst1 = 1'b1; start1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0; start1 = 1'b0;
    check("midscan_reset", 32'({vec1, busy1, done1, tt1, ones1, mm1, ff1}), 32'd0);
    @(negedge clk);
    check("rst_start_ignored", 32'(busy1), 32'd0);
    kick(0, 1'b0);
    finish(1);

    // Start held high through a scan: restart after the IDLE cycle
    kick(0, 1'b1);
    finish(1);
    @(negedge clk);
    check("restart_busy", 32'(busy1), 32'd1);
    check("restart_tt_clr", 32'(tt1), 32'd0);
    check("restart_ones_clr", 32'(ones1), 32'd0);
    sb.push_back(model_scan(0));
    start1 = 1'b0;
    finish(1);

    // SETTLE=0 instance
    sel = 0;
    kick(0, 1'b0);
    finish(0);
    check("s0_golden_tt", 32'(s_tt), 32'h0000_F232);
    kick(3, 1'b0);
    finish(0);
    check("s0_flip9_tt", 32'(s_tt), 32'h0000_F032);
    check("s0_flip9_ones", 32'(s_ones), 32'd7);
    check("s0_flip9_ff", 32'(s_ff), 32'd9);
    check("s0_flip9_mm", 32'(s_mm), 32'd1);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
